// File: rtl/activation_quant_pipe.sv
// rtl/activation_quant_pipe.sv - multi-lane requantize (scale, round-shift) + activation + saturate, 3-stage pipe
// Beats are captured at the input, then scaled, round-shifted and activated on successive enabled edges.
module activation_quant_pipe #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int MULT_WIDTH   = 16,
  parameter int SHIFT_WIDTH  = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*INPUT_WIDTH-1:0]    ofm_input,
  input  logic [MULT_WIDTH-1:0]           cfg_mult,
  input  logic [SHIFT_WIDTH-1:0]          cfg_shift,
  input  logic [1:0]                      cfg_mode,
  input  logic [OUTPUT_WIDTH-2:0]         cfg_clip,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*OUTPUT_WIDTH-1:0]   ofm_output,
  output logic [LANES-1:0]                out_sat,
  input  logic                            sat_clr,
  output logic [CNT_WIDTH-1:0]            sat_count
);

  localparam int PW = INPUT_WIDTH + MULT_WIDTH + 1;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] POS_MAX = {{(RW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] NEG_MIN = ~POS_MAX;

  logic                                 en;
  logic                                 s0_valid_q, s1_valid_q, s2_valid_q, out_valid_q;
  logic [LANES*INPUT_WIDTH-1:0]         s0_data_q;
  logic [MULT_WIDTH-1:0]                s0_mult_q;
  logic [SHIFT_WIDTH-1:0]               s0_shift_q, s1_shift_q;
  logic [1:0]                           s0_mode_q, s1_mode_q, s2_mode_q;
  logic [OUTPUT_WIDTH-2:0]              s0_clip_q, s1_clip_q, s2_clip_q;
  logic [LANES-1:0][PW-1:0]             prod_d, s1_prod_q;
  logic [LANES-1:0][RW-1:0]             r_d, s2_r_q;
  logic [LANES-1:0][OUTPUT_WIDTH-1:0]   res_d, ofm_q;
  logic [LANES-1:0]                     sat_d, sat_q;
  logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;

  logic signed [PW-1:0] a_ext, m_ext;
  logic signed [RW-1:0] p_ext, bias, sum, r_s, clip_ext;

  assign en         = !out_valid_q || out_ready;
  assign in_ready   = en;
  assign out_valid  = out_valid_q;
  assign ofm_output = ofm_q;
  assign out_sat    = sat_q;
  assign sat_count  = cnt_q;

  // Operands are widened to the full product width so the multiply never truncates.
  always_comb begin
    a_ext = '0;
    m_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext = {{(PW-INPUT_WIDTH){s0_data_q[i*INPUT_WIDTH+INPUT_WIDTH-1]}},
               s0_data_q[i*INPUT_WIDTH +: INPUT_WIDTH]};
      m_ext = {{(PW-MULT_WIDTH){1'b0}}, s0_mult_q};
      prod_d[i] = a_ext * m_ext;
    end
  end

  // One guard bit above the product keeps the rounding add from overflowing.
  always_comb begin
    p_ext = '0;
    bias  = '0;
    sum   = '0;
    for (int i = 0; i < LANES; i++) begin
      p_ext = {s1_prod_q[i][PW-1], s1_prod_q[i]};
      bias  = (s1_shift_q == '0) ? '0 : (RW'(1) << (s1_shift_q - SHIFT_WIDTH'(1)));
      sum   = p_ext + bias;
      r_d[i] = sum >>> s1_shift_q;
    end
  end

  always_comb begin
    r_s      = '0;
    clip_ext = {{(RW-OUTPUT_WIDTH+1){1'b0}}, s2_clip_q};
    for (int i = 0; i < LANES; i++) begin
      r_s      = s2_r_q[i];
      res_d[i] = r_s[OUTPUT_WIDTH-1:0];
      sat_d[i] = 1'b0;
      case (s2_mode_q)
        2'd1: begin
          if (r_s[RW-1]) begin
            res_d[i] = '0;
          end else if (r_s > POS_MAX) begin
            res_d[i] = POS_MAX[OUTPUT_WIDTH-1:0];
            sat_d[i] = 1'b1;
          end
        end
        2'd2: begin
          if (r_s[RW-1]) begin
            res_d[i] = '0;
          end else if (r_s > clip_ext) begin
            res_d[i] = clip_ext[OUTPUT_WIDTH-1:0];
            sat_d[i] = 1'b1;
          end
        end
        default: begin
          if (r_s > POS_MAX) begin
            res_d[i] = POS_MAX[OUTPUT_WIDTH-1:0];
            sat_d[i] = 1'b1;
          end else if (r_s < NEG_MIN) begin
            res_d[i] = NEG_MIN[OUTPUT_WIDTH-1:0];
            sat_d[i] = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready && (sat_q != '0) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ofm_q       <= '0;
      sat_q       <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        s0_valid_q  <= in_valid;
        s1_valid_q  <= s0_valid_q;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          ofm_q <= res_d;
          sat_q <= sat_d;
        end else begin
          sat_q <= '0;
        end
      end
    end
  end

  // Datapath registers carry no reset; only the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (en) begin
      s0_data_q  <= ofm_input;
      s0_mult_q  <= cfg_mult;
      s0_shift_q <= cfg_shift;
      s0_mode_q  <= cfg_mode;
      s0_clip_q  <= cfg_clip;
      s1_prod_q  <= prod_d;
      s1_shift_q <= s0_shift_q;
      s1_mode_q  <= s0_mode_q;
      s1_clip_q  <= s0_clip_q;
      s2_r_q     <= r_d;
      s2_mode_q  <= s1_mode_q;
      s2_clip_q  <= s1_clip_q;
    end
  end

endmodule

// File: tb/tb_activation_quant_pipe.sv
// tb/tb_activation_quant_pipe.sv - self-checking bench for activation_quant_pipe
// Expected beats come from an integer-arithmetic model evaluated at each accepted handshake.
module tb_activation_quant_pipe;
  localparam int IW = 32, OW = 8, L = 4, MW = 16, SW = 5, CW = 16;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
  logic [L*IW-1:0] ofm_input = '0;
  logic [MW-1:0] cfg_mult = '0;
  logic [SW-1:0] cfg_shift = '0;
  logic [1:0] cfg_mode = '0;
  logic [OW-2:0] cfg_clip = '0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [L*OW-1:0] ofm_output, ofm_output2;
  logic [L-1:0] out_sat, out_sat2;
  logic [CW-1:0] sat_count;
  logic [1:0] sat_count2;

  int n_vec = 0, n_err = 0;
  int ir_viol = 0, stab_viol = 0;
  bit was_stall = 0, last_acc = 0;
  logic [L*OW-1:0] stall_d;
  logic [L-1:0] stall_s;
  logic [L*OW-1:0] exp_d[$], obs_d[$];
  logic [L-1:0] exp_s[$], obs_s[$];

  activation_quant_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ofm_input(ofm_input),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .out_valid(out_valid), .out_ready(out_ready), .ofm_output(ofm_output), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_count(sat_count));

  activation_quant_pipe #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .ofm_input(ofm_input),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .out_valid(out_valid2), .out_ready(out_ready), .ofm_output(ofm_output2), .out_sat(out_sat2),
    .sat_clr(sat_clr), .sat_count(sat_count2));

  always #5 clk = ~clk;

  // Reference: exact integer scale, round-half-up divide by 2^shift, then the activation rule.
  task automatic model_push();
    logic [L*OW-1:0] d;
    logic [L-1:0] s;
    longint x, p, num, den, r, y;
    int m;
    for (int i = 0; i < L; i++) begin
      x = longint'($signed(ofm_input[i*IW +: IW]));
      p = x * longint'(cfg_mult);
      if (cfg_shift == 0) r = p;
      else begin
        den = longint'(1) << cfg_shift;
        num = p + den / 2;
        r = num / den;
        if ((num % den) != 0 && num < 0) r = r - 1;
      end
      m = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
      s[i] = 1'b0;
      y = r;
      if (m == 0) begin
        if (r > 127) begin y = 127; s[i] = 1'b1; end
        else if (r < -128) begin y = -128; s[i] = 1'b1; end
      end else if (m == 1) begin
        if (r < 0) y = 0;
        else if (r > 127) begin y = 127; s[i] = 1'b1; end
      end else begin
        if (r < 0) y = 0;
        else if (r > longint'(cfg_clip)) begin y = longint'(cfg_clip); s[i] = 1'b1; end
      end
      d[i*OW +: OW] = y[OW-1:0];
    end
    exp_d.push_back(d);
    exp_s.push_back(s);
  endtask

  task automatic step();
    #1;
    last_acc = rst_n && in_valid && in_ready;
    if (last_acc) model_push();
    if (rst_n && out_valid && out_ready) begin
      obs_d.push_back(ofm_output);
      obs_s.push_back(out_sat);
    end
    if (rst_n && out_valid && !out_ready) begin
      if (in_ready) ir_viol++;
      if (was_stall && (ofm_output !== stall_d || out_sat !== stall_s)) stab_viol++;
      was_stall = 1;
      stall_d = ofm_output;
      stall_s = out_sat;
    end else was_stall = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a, input int b, input int c, input int d);
    ofm_input = {d, c, b, a};
  endtask

  task automatic set_cfg(input int mult, input int shift, input int mode, input int clip);
    cfg_mult = MW'(mult); cfg_shift = SW'(shift); cfg_mode = 2'(mode); cfg_clip = (OW-1)'(clip);
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 40 && obs_d.size() < exp_d.size(); i++) step();
    step();
  endtask

  task automatic clear_q();
    exp_d.delete(); exp_s.delete(); obs_d.delete(); obs_s.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (ofm_output !== '0) begin n_err++; $display("FAIL reset_ofm got %h want 0", ofm_output); end
    if (out_sat !== '0) begin n_err++; $display("FAIL reset_sat got %b want 0", out_sat); end
    if (sat_count !== '0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", sat_count); end
    rst_n = 1;
    step();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_identity();
    clear_q();
    set_cfg(1, 0, 0, 0);
    set_beat(100, 300, -300, -128);
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1 got %b want 0", out_valid); end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_n2 got %b want 0", out_valid); end
    step();
    n_vec += 3;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_n3 got %b want 1", out_valid); end
    if (ofm_output !== 32'h80807f64) begin n_err++; $display("FAIL ident_data got %h want 80807f64", ofm_output); end
    if (out_sat !== 4'b0110) begin n_err++; $display("FAIL ident_sat got %b want 0110", out_sat); end
    step();
    n_vec++;
    if (sat_count !== 16'd1) begin n_err++; $display("FAIL ident_cnt got %0d want 1", sat_count); end
  endtask

  task automatic test_rounding();
    clear_q();
    in_valid = 1;
    set_cfg(1, 1, 0, 0); set_beat(3, -3, 5, -1); step();
    set_cfg(3, 2, 0, 0); set_beat(10, 0, 0, 0); step();
    drain();
    n_vec++;
    if (obs_d.size() != 2) begin n_err++; $display("FAIL round_count got %0d want 2", obs_d.size()); end
    else begin
      n_vec += 3;
      if (obs_d[0] !== 32'h0003ff02) begin n_err++; $display("FAIL round_half got %h want 0003ff02", obs_d[0]); end
      if (obs_s[0] !== 4'b0000) begin n_err++; $display("FAIL round_sat got %b want 0000", obs_s[0]); end
      if (obs_d[1] !== 32'h00000008) begin n_err++; $display("FAIL round_scale got %h want 00000008", obs_d[1]); end
    end
  endtask

  task automatic test_relu();
    logic [L*OW-1:0] wd[4];
    logic [L-1:0] ws[4];
    wd = '{32'h7f320000, 32'h03000606, 32'hfb05807f, 32'h00000000};
    ws = '{4'b1000, 4'b0001, 4'b0011, 4'b1001};
    clear_q();
    in_valid = 1;
    set_cfg(1, 0, 1, 0); set_beat(-5, 0, 50, 1000); step();
    set_cfg(1, 0, 2, 6); set_beat(10, 6, -2, 3); step();
    set_cfg(1, 0, 3, 0); set_beat(300, -300, 5, -5); step();
    set_cfg(1, 0, 2, 0); set_beat(10, -1, 0, 5); step();
    drain();
    n_vec++;
    if (obs_d.size() != 4) begin n_err++; $display("FAIL relu_count got %0d want 4", obs_d.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec += 2;
      if (obs_d[i] !== wd[i]) begin n_err++; $display("FAIL relu_data[%0d] got %h want %h", i, obs_d[i], wd[i]); end
      if (obs_s[i] !== ws[i]) begin n_err++; $display("FAIL relu_sat[%0d] got %b want %b", i, obs_s[i], ws[i]); end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    clear_q();
    ir_viol = 0; stab_viol = 0;
    for (int c = 0; c < 200 && sent < 10; c++) begin
      in_valid = 1;
      set_cfg(1 + sent % 3, sent % 2, 0, 0);
      set_beat(sent * 10, sent * 10 + 1, -sent * 10, sent * 30);
      out_ready = !((c >= 4 && c < 9) || (c % 3 == 2));
      step();
      if (last_acc) sent++;
    end
    drain();
    n_vec += 3;
    if (obs_d.size() != 10) begin n_err++; $display("FAIL bp_count got %0d want 10", obs_d.size()); end
    if (ir_viol != 0) begin n_err++; $display("FAIL bp_in_ready got %0d violations want 0", ir_viol); end
    if (stab_viol != 0) begin n_err++; $display("FAIL bp_stable got %0d violations want 0", stab_viol); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      n_vec++;
      if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i])
        begin n_err++; $display("FAIL bp_beat[%0d] got %h/%b want %h/%b", i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]); end
    end
  endtask

  task automatic test_counter();
    sat_clr = 1; step(); sat_clr = 0;
    n_vec++;
    if (sat_count !== '0) begin n_err++; $display("FAIL cnt_clr got %0d want 0", sat_count); end
    set_cfg(1, 0, 0, 0); set_beat(1000, 0, 0, 0);
    in_valid = 1; for (int i = 0; i < 3; i++) step();
    drain();
    n_vec += 2;
    if (sat_count !== 16'd3) begin n_err++; $display("FAIL cnt_three got %0d want 3", sat_count); end
    if (sat_count2 !== 2'd3) begin n_err++; $display("FAIL cnt2_three got %0d want 3", sat_count2); end
    in_valid = 1; step(); step();
    drain();
    n_vec += 2;
    if (sat_count !== 16'd5) begin n_err++; $display("FAIL cnt_five got %0d want 5", sat_count); end
    if (sat_count2 !== 2'd3) begin n_err++; $display("FAIL cnt2_stick got %0d want 3", sat_count2); end
    in_valid = 1; step(); in_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin sat_clr = 1; step(); sat_clr = 0; break; end
      step();
    end
    n_vec += 2;
    if (sat_count !== '0) begin n_err++; $display("FAIL cnt_clr_wins got %0d want 0", sat_count); end
    if (sat_count2 !== '0) begin n_err++; $display("FAIL cnt2_clr_wins got %0d want 0", sat_count2); end
  endtask

  task automatic test_reset_midstream();
    set_cfg(1, 0, 0, 0); set_beat(-1000, 0, 0, 0);
    in_valid = 1; step();
    drain();
    in_valid = 1; step(); step(); step();
    in_valid = 0;
    rst_n = 0;
    step();
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    if (sat_count !== '0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", sat_count); end
    rst_n = 1;
    clear_q();
    for (int i = 0; i < 8; i++) step();
    n_vec++;
    if (obs_d.size() != 0) begin n_err++; $display("FAIL mid_rst_stale got %0d beats want 0", obs_d.size()); end
  endtask

  task automatic test_random();
    int sent = 0;
    int x[4];
    clear_q();
    for (int c = 0; c < 2000 && sent < 60; c++) begin
      for (int i = 0; i < 4; i++)
        x[i] = ($urandom_range(0, 2) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
      set_beat(x[0], x[1], x[2], x[3]);
      set_cfg(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 127)));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (last_acc) sent++;
    end
    drain();
    n_vec++;
    if (obs_d.size() != exp_d.size() || sent != 60)
      begin n_err++; $display("FAIL rand_count got %0d/%0d want %0d", obs_d.size(), sent, exp_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      n_vec++;
      if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i])
        begin n_err++; $display("FAIL rand_beat[%0d] got %h/%b want %h/%b", i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_relu();
    test_backpressure();
    test_counter();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/activation_quant_pipe.md
Name: activation_quant_pipe

Overview:
Multi-lane requantization and activation stage that follows the convolution accumulators. Each lane takes a wide signed partial sum and applies per-beat fixed-point scaling (multiply, then round-shift), then the selected activation (identity / ReLU / clipped ReLU), then saturates to OUTPUT_WIDTH. The block is a 3-stage pipeline with valid/ready handshakes on both sides and a saturation-event counter. It sits between the accumulator array and the OFM write buffer.

Parameters:
INPUT_WIDTH, 32, signed accumulator width per lane
OUTPUT_WIDTH, 8, signed output width per lane
LANES, 4, parallel channels processed per beat
MULT_WIDTH, 16, unsigned scale multiplier width
SHIFT_WIDTH, 5, right-shift amount width
CNT_WIDTH, 16, saturation counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
ofm_input  in  LANES*INPUT_WIDTH  packed signed lanes; lane 0 in the LSBs
cfg_mult  in  MULT_WIDTH  unsigned scale, sampled with the beat
cfg_shift  in  SHIFT_WIDTH  right shift, sampled with the beat
cfg_mode  in  2  0 identity, 1 ReLU, 2 clipped ReLU, 3 reserved (treated as 0)
cfg_clip  in  OUTPUT_WIDTH-1  unsigned upper clamp for mode 2
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
ofm_output  out  LANES*OUTPUT_WIDTH  packed signed results
out_sat  out  LANES  per-lane saturation/clip flag for the current output beat
sat_clr  in  1  clears sat_count
sat_count  out  CNT_WIDTH  number of output beats with any out_sat bit set

Behaviour:
- Reset (rst_n=0 at an edge): all stage-valid bits, out_valid, ofm_output, out_sat, and sat_count go to 0. In-flight beats are discarded. in_ready is 1 in the cycle after reset is released.
- Handshake: a beat is transferred on any edge with valid&&ready. Global pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational). While en=0, every stage register holds its value. ofm_output, out_sat and out_valid are stable while out_valid && !out_ready.
- Stages may hold bubbles. Each stage carries a valid bit and the config captured at acceptance, so a config change between beats affects only later beats.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+3 when there is no stall. Throughput is 1 beat/cycle.
- S1: prod = signed(ofm_input lane) * {1'b0, cfg_mult}, computed at full width INPUT_WIDTH+MULT_WIDTH+1.
- S2: if shift==0, r = prod. Otherwise r = (prod + (1 << (shift-1))) >>> shift, using an arithmetic shift. Rounding is half toward +inf. No overflow is possible in the add, because the computation uses one guard bit.
- S3, by mode:
  - mode 0/3: clamp r to [-2^(OW-1), 2^(OW-1)-1].
  - mode 1: r<0 gives 0; otherwise clamp to 2^(OW-1)-1.
  - mode 2: r<0 gives 0; otherwise clamp to cfg_clip. cfg_clip=0 forces all outputs to 0.
- out_sat[i] = 1 when lane i was clamped to a bound: the signed bounds in mode 0/3, the positive bound in mode 1, or cfg_clip in mode 2. Zeroing of negatives by ReLU does not set out_sat.
- sat_count: increments by 1 on each output handshake whose out_sat != 0. It saturates at all-ones with no wrap. If sat_clr and an increment occur on the same edge, the clear wins and the result is 0.
- X/Z on ofm_input: the output is unspecified, but must not corrupt the valid bits or the counter.

Test Plan:
- Identity (mode 0, mult=1, shift=0), lane inputs {100, 300, -300, -128} -> outputs {100, 127, -128, -128}, out_sat=4'b0110, sat_count=1; out_valid is high exactly 3 cycles after acceptance.
- Rounding (mult=1, shift=1, mode 0), inputs {3, -3, 5, -1} -> {2, -1, 3, 0}. Scaling: mult=3, shift=2, input 10 -> 8 (30/4=7.5 rounds to 8).
- ReLU / clipped ReLU: mode 1, inputs {-5, 0, 50, 1000} -> {0, 0, 50, 127}, out_sat=4'b1000. Mode 2 with clip=6, inputs {10, 6, -2, 3} -> {6, 6, 0, 3}, out_sat=4'b0001.
- Backpressure: stream 10 beats with incrementing inputs while out_ready toggles (low for 5 cycles mid-stream) -> no loss or duplication, output stable while stalled, in_ready=0 during the stall, order preserved, config applied per beat.
- Counter: 3 saturating beats -> sat_count=3. sat_clr on the same edge as a 4th saturating handshake -> sat_count=0. Preloading near max (CNT_WIDTH=2 build) sticks at 3.
- Reset mid-stream with 3 beats in flight -> out_valid=0 after the next edge, sat_count=0, no stale beats emerge after release.
